// File: rtl/latch_bank_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// latch_bank_sequencer_pkg -- state encodings and width helper for the
// latch bank write sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
package latch_bank_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ENABLE = 2'd2,
      HOLD   = 2'd3
   } state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/latch_bank_sequencer_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin pick: first asserted request at or
// after ptr_i, wrapping NREQ-1 -> 0.  Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
   import latch_bank_sequencer_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]          req_i,
   input  logic [clog2(NREQ)-1:0]   ptr_i,
   output logic [NREQ-1:0]          gnt_o
);

   localparam int PTR_W = clog2(NREQ);

   always_comb begin
      logic             found;
      logic [PTR_W-1:0] idx;
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PTR_W'((int'(ptr_i) + k) % NREQ);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/latch_bank_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// latch_bank_sequencer -- arbitrates NREQ writers onto one transparent latch
// bank with setup/pulse/hold sequencing.  Optional: LATCH_SEQ_READBACK_CHECK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module latch_bank_sequencer
   import latch_bank_sequencer_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int W         = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*W-1:0]  wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic [W-1:0]       latch_d,
   output logic               latch_e,
   input  logic [W-1:0]       latch_q
`ifdef LATCH_SEQ_READBACK_CHECK_EN
   ,
   output logic               rb_err
`endif
);

   localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
   localparam int CNT_W   = clog2(MAX_CYC) + 1;
   localparam int PTR_W   = clog2(NREQ);

   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   done_q;
   logic [W-1:0]      latch_d_q;
   logic              latch_e_q;
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  idx_q;

   logic [NREQ-1:0]   gnt_d;
   logic [PTR_W-1:0]  idx_d;
   logic [W-1:0]      data_d;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (gnt_d)
   );

   always_comb begin
      idx_d  = '0;
      data_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_d[i]) begin
            idx_d  = PTR_W'(i);
            data_d = wdata[i*W +: W];
         end
      end
   end

   // Counter holds remaining cycles minus one; reloaded on every state entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         latch_d_q <= '0;
         latch_e_q <= 1'b0;
         ptr_q     <= '0;
         idx_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req) begin
                  gnt_q     <= gnt_d;
                  idx_q     <= idx_d;
                  latch_d_q <= data_d;
                  cnt_q     <= SETUP_LOAD;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_q == '0) begin
                  latch_e_q <= 1'b1;
                  cnt_q     <= PULSE_LOAD;
                  state_q   <= ENABLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ENABLE: begin
               if (cnt_q == '0) begin
                  latch_e_q <= 1'b0;
                  cnt_q     <= HOLD_LOAD;
                  done_q    <= (HOLD_LOAD == '0) ? gnt_q : '0;
                  state_q   <= HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            HOLD: begin
               if (cnt_q == '0) begin
                  done_q  <= '0;
                  gnt_q   <= '0;
                  ptr_q   <= (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     done_q <= gnt_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign busy    = (state_q != IDLE);
   assign latch_d = latch_d_q;
   assign latch_e = latch_e_q;

`ifdef LATCH_SEQ_READBACK_CHECK_EN
   logic rb_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rb_err_q <= 1'b0;
      end else if (state_q == HOLD && cnt_q == '0 && latch_q != latch_d_q) begin
         rb_err_q <= 1'b1;
      end
   end

   assign rb_err = rb_err_q;
`else
   logic unused_latch_q;
   assign unused_latch_q = ^latch_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_latch_bank_sequencer -- directed self-checking bench with a behavioural
// transparent latch bank on the d/e outputs.  Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_latch_bank_sequencer;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic               clk   = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req   = '0;
   logic [NREQ*W-1:0]  wdata = '0;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [W-1:0]       latch_d;
   logic               latch_e;
   logic [W-1:0]       latch_q;
   logic [W-1:0]       bank_q = '0;
   logic [W-1:0]       bank_nq;
   logic               force_zero = 1'b0;
`ifdef LATCH_SEQ_READBACK_CHECK_EN
   logic               rb_err;
`endif

   int n_err = 0;
   int n_chk = 0;

   latch_bank_sequencer #(
      .NREQ(NREQ), .W(W), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .wdata   (wdata),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .latch_d (latch_d),
      .latch_e (latch_e),
      .latch_q (latch_q)
`ifdef LATCH_SEQ_READBACK_CHECK_EN
      ,
      .rb_err  (rb_err)
`endif
   );

   always #5 clk = ~clk;

   always @(latch_e or latch_d) if (latch_e) bank_q = latch_d;
   assign bank_nq = ~bank_q;
   assign latch_q = force_zero ? '0 : bank_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Waits for grant and done, checking latency and captured data.
   task automatic do_txn(input int exp_idx, input logic [W-1:0] exp_data);
      int n;
      n = 0;
      while (gnt == '0 && n < 10) begin
         tick();
         n++;
      end
      check("gnt", gnt, 32'(1) << exp_idx);
      check("gnt_data", latch_d, exp_data);
      n = 0;
      while (done == '0 && n < 10) begin
         tick();
         n++;
      end
      check("gnt_to_done", n, 3);
      check("done", done, 32'(1) << exp_idx);
      check("bank_q", latch_q, exp_data);
      tick();
      check("done_clr", done, 0);
   endtask

   // latch_d must not move while the bank is transparent or as e rises.
   logic [W-1:0] prev_d = '0;
   always @(posedge clk) begin
      #1;
      if (latch_e) check("d_stable_while_e", latch_d, prev_d);
      prev_d = latch_d;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_e", latch_e, 0);
      check("rst_d", latch_d, 0);
`ifdef LATCH_SEQ_READBACK_CHECK_EN
      check("rst_rb_err", rb_err, 0);
`endif

      // Single request from requester 2.
      wdata[2*W +: W] = 8'hA5;
      req = 4'b0100;
      tick();
      check("t1_gnt", gnt, 4'b0100);
      check("t1_busy", busy, 1);
      check("t1_e_setup", latch_e, 0);
      check("t1_d", latch_d, 8'hA5);
      tick();
      check("t1_e_on1", latch_e, 1);
      check("t1_done_early", done, 0);
      tick();
      check("t1_e_on2", latch_e, 1);
      tick();
      check("t1_e_off", latch_e, 0);
      check("t1_done", done, 4'b0100);
      check("t1_q", latch_q, 8'hA5);
      check("t1_nq", bank_nq, 8'h5A);
      req = '0;
      tick();
      check("t1_done_clr", done, 0);
      check("t1_idle_gnt", gnt, 0);
      check("t1_idle_busy", busy, 0);
`ifdef LATCH_SEQ_READBACK_CHECK_EN
      check("t1_rb_ok", rb_err, 0);
`endif

      // Contention: strict round-robin from index 0.
      do_reset();
      wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      do_txn(0, 8'h10);
      do_txn(1, 8'h11);
      do_txn(2, 8'h12);
      do_txn(3, 8'h13);
      do_txn(0, 8'h10);

      // Data stability: wdata changes during ENABLE are ignored.
      do_reset();
      wdata[1*W +: W] = 8'h3C;
      req = 4'b0010;
      tick();
      check("t3_gnt", gnt, 4'b0010);
      tick();
      check("t3_e_on", latch_e, 1);
      wdata[1*W +: W] = 8'hC3;
      tick();
      tick();
      check("t3_done", done, 4'b0010);
      check("t3_d", latch_d, 8'h3C);
      check("t3_q", latch_q, 8'h3C);
      req = '0;
      tick();

      // Reset mid-ENABLE; pointer is 2 here so requester 3 wins first.
      wdata[3*W +: W] = 8'h77;
      wdata[1*W +: W] = 8'h55;
      req = 4'b1010;
      tick();
      check("t4_gnt", gnt, 4'b1000);
      tick();
      check("t4_e_on", latch_e, 1);
      rst_n = 1'b0;
      tick();
      check("t4_abort_e", latch_e, 0);
      check("t4_abort_gnt", gnt, 0);
      check("t4_abort_busy", busy, 0);
      check("t4_abort_done", done, 0);
      check("t4_bank_kept", latch_q, 8'h77);
      rst_n = 1'b1;
      do_txn(1, 8'h55);
      req = '0;

      // req dropped during SETUP still completes.
      do_reset();
      wdata[1*W +: W] = 8'h9A;
      req = 4'b0010;
      tick();
      check("t5_gnt", gnt, 4'b0010);
      req = '0;
      do_txn(1, 8'h9A);
      check("t5_idle", busy, 0);

`ifdef LATCH_SEQ_READBACK_CHECK_EN
      do_reset();
      force_zero = 1'b1;
      wdata[0 +: W] = 8'hFF;
      req = 4'b0001;
      tick();
      tick();
      tick();
      tick();
      check("rb_done", done, 4'b0001);
      check("rb_before", rb_err, 0);
      req = '0;
      tick();
      check("rb_set", rb_err, 1);
      tick();
      tick();
      check("rb_sticky", rb_err, 1);
      force_zero = 1'b0;
      do_reset();
      check("rb_cleared", rb_err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
